// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential divider controller.
//   DIV_WIDTH   default operand/result width
//   DIV_CNT_W   default iteration counter width (2**DIV_CNT_W must exceed DIV_WIDTH)
//   div_state_t controller state encoding, also visible on the state_dbg port
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: request/result handshake bundle between EXE (master) and
// the divider controller (slave).
//   req_valid/req_ready  request handshake; req_signed, req_x, req_y qualify it
//   res_valid/res_ready  result handshake; res_q, res_r qualify it
// Handshake rule: a transfer happens on a rising clock edge where valid and
// ready are both 1; payload must be stable while valid is high and ready low.
interface div_seq_ctrl_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             req_valid;
    logic             req_ready;
    logic             req_signed;
    logic [WIDTH-1:0] req_x;
    logic [WIDTH-1:0] req_y;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;

    modport master (
        output req_valid, req_signed, req_x, req_y, res_ready,
        input  req_ready, res_valid, res_q, res_r
    );

    modport slave (
        input  req_valid, req_signed, req_x, req_y, res_ready,
        output req_ready, res_valid, res_q, res_r
    );

endinterface

// File: rtl/div_step_core.sv
// div_step_core: one restoring shift-subtract step, purely combinational.
//   rem       partial remainder (magnitude)
//   shf       dividend shift register; quotient bits enter at the LSB
//   y_mag     divisor magnitude
//   rem_next  partial remainder after this step
//   shf_next  shift register after this step
module div_step_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] shf,
    input  logic [WIDTH-1:0] y_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] shf_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        // The shifted remainder needs WIDTH+1 bits: it can reach 2*y_mag-1.
        shifted = {rem, shf[WIDTH-1]};
        diff    = shifted - {1'b0, y_mag};
        // A set top bit means the subtraction went negative: restore.
        if (diff[WIDTH]) begin
            rem_next = shifted[WIDTH-1:0];
            shf_next = {shf[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = diff[WIDTH-1:0];
            shf_next = {shf[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencing controller for the iterative EXE-stage divider.
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   cancel     pipeline flush; kills any in-flight or held operation
//   busy       controller is not IDLE
//   state_dbg  current FSM state (div_state_t encoding)
//   bus        request/result handshake (div_seq_ctrl_if.slave)
// Flow: IDLE -> PREP -> ITER x WIDTH -> FIX -> DONE, holding the result in
// DONE until res_ready. A zero divisor skips ITER.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         cancel,
    output logic         busy,
    output logic [2:0]   state_dbg,
    div_seq_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             sgn_lat;
    logic [WIDTH-1:0] x_lat;
    logic [WIDTH-1:0] y_lat;
    logic [WIDTH-1:0] y_mag;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] shf;
    logic             sign_q;
    logic             sign_r;
    logic             res_valid_r;
    logic [WIDTH-1:0] res_q_r;
    logic [WIDTH-1:0] res_r_r;

    logic             accept;
    logic             x_neg;
    logic             y_neg;
    logic             y_zero;
    logic [WIDTH-1:0] x_abs;
    logic [WIDTH-1:0] y_abs;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] shf_next;

    assign bus.req_ready = ~cancel & ((state == IDLE) | ((state == DONE) & bus.res_ready));
    assign accept        = bus.req_valid & bus.req_ready;

    assign x_neg  = sgn_lat & x_lat[WIDTH-1];
    assign y_neg  = sgn_lat & y_lat[WIDTH-1];
    assign y_zero = (y_lat == '0);
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign x_abs  = x_neg ? -x_lat : x_lat;
    assign y_abs  = y_neg ? -y_lat : y_lat;

    div_step_core #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .shf      (shf),
        .y_mag    (y_mag),
        .rem_next (rem_next),
        .shf_next (shf_next)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            sgn_lat     <= 1'b0;
            x_lat       <= '0;
            y_lat       <= '0;
            y_mag       <= '0;
            rem         <= '0;
            shf         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_q_r     <= '0;
            res_r_r     <= '0;
        end else if (cancel) begin
            state       <= IDLE;
            cnt         <= '0;
            res_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sgn_lat <= bus.req_signed;
                        x_lat   <= bus.req_x;
                        y_lat   <= bus.req_y;
                        state   <= PREP;
                    end
                end
                PREP: begin
                    cnt   <= '0;
                    y_mag <= y_abs;
                    if (y_zero) begin
                        // Route through FIX with sign correction off so the
                        // output registers load from one place: q=~0, r=x raw.
                        rem    <= x_lat;
                        shf    <= '1;
                        sign_q <= 1'b0;
                        sign_r <= 1'b0;
                        state  <= FIX;
                    end else begin
                        rem    <= '0;
                        shf    <= x_abs;
                        sign_q <= x_neg ^ y_neg;
                        sign_r <= x_neg;
                        state  <= ITER;
                    end
                end
                ITER: begin
                    rem <= rem_next;
                    shf <= shf_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    res_q_r     <= sign_q ? -shf : shf;
                    res_r_r     <= sign_r ? -rem : rem;
                    res_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        if (accept) begin
                            sgn_lat <= bus.req_signed;
                            x_lat   <= bus.req_x;
                            y_lat   <= bus.req_y;
                            state   <= PREP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.res_valid = res_valid_r;
    assign bus.res_q     = res_q_r;
    assign bus.res_r     = res_r_r;
    assign busy          = (state != IDLE);
    assign state_dbg     = state;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed + small random stimulus for div_seq_ctrl with an
// expected-result queue filled at issue time and drained when res_valid rises.
module tb_div_seq_ctrl;
    import div_pkg::*;

    localparam int W = 32;

    logic       clk;
    logic       resetn;
    logic       cancel;
    logic       busy;
    logic [2:0] state_dbg;

    div_seq_ctrl_if #(.WIDTH(W)) bus ();

    div_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cancel    (cancel),
        .busy      (busy),
        .state_dbg (state_dbg),
        .bus       (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: divide magnitudes, then apply the sign of the quotient
    // (sx^sy) and remainder (sx); divide by zero gives q=~0, r=x.
    task automatic model(input logic sgn, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] q, output logic [W-1:0] r);
        logic [W-1:0] ax, ay, mq, mr;
        logic nx, ny;
        if (y == '0) begin
            q = '1;
            r = x;
        end else begin
            nx = sgn & x[W-1];
            ny = sgn & y[W-1];
            ax = nx ? (~x + 1'b1) : x;
            ay = ny ? (~y + 1'b1) : y;
            mq = ax / ay;
            mr = ax % ay;
            q  = (nx ^ ny) ? (~mq + 1'b1) : mq;
            r  = nx ? (~mr + 1'b1) : mr;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic sgn, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        bus.req_valid  = 1'b1;
        bus.req_signed = sgn;
        bus.req_x      = x;
        bus.req_y      = y;
        #1;
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // n counts rising edges since the accept edge.
    task automatic wait_result(input string tag, input int exp_lat);
        int n = 0;
        logic [2*W-1:0] e;
        while (bus.res_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " pending"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " q"}, bus.res_q, e[2*W-1:W]);
            check({tag, " r"}, bus.res_r, e[W-1:0]);
        end
    endtask

    task automatic release_check(input string tag);
        @(negedge clk);
        check({tag, " valid_drop"}, 32'(bus.res_valid), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic sgn, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] q, input logic [W-1:0] r, input int lat,
                          input string tag);
        exp_q.push_back({q, r});
        issue(sgn, x, y, tag);
        wait_result(tag, lat);
        release_check(tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] rq, rr, rx, ry;
        logic rs;
        int rises;

        resetn         = 1'b0;
        cancel         = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.res_ready  = 1'b1;

        repeat (2) @(negedge clk);
        check("rst res_valid", 32'(bus.res_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst res_q", bus.res_q, 32'd0);
        check("rst res_r", bus.res_r, 32'd0);
        check("rst state", 32'(state_dbg), 32'(IDLE));
        resetn = 1'b1;
        #1;
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);

        // Basic unsigned / signed / overflow / divide-by-zero.
        run_op(1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 34, "u7_2");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, "s-7_2");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34, "s_ovf");
        run_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 2, "u5_0");
        run_op(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 2, "s5_0");

        // Cancel mid-iteration; a request presented with cancel must be dropped.
        issue(1'b0, 32'd100, 32'd7, "cancel_op");
        repeat (9) @(negedge clk);
        cancel         = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_x      = 32'd9;
        bus.req_y      = 32'd4;
        #1;
        check("cancel req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        cancel        = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("cancel res_valid", 32'(bus.res_valid), 32'd0);
        check("cancel busy", 32'(busy), 32'd0);
        check("cancel state", 32'(state_dbg), 32'(IDLE));
        check("cancel ready_after", 32'(bus.req_ready), 32'd1);
        rises = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) rises++;
        end
        check("cancel no_result", 32'(rises), 32'd0);
        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, "after_cancel");

        // Hold the result in DONE, then accept back-to-back on release.
        bus.res_ready = 1'b0;
        exp_q.push_back({32'd8, 32'd2});
        issue(1'b0, 32'd50, 32'd6, "hold");
        wait_result("hold", 34);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold valid", 32'(bus.res_valid), 32'd1);
            check("hold q", bus.res_q, 32'd8);
            check("hold r", bus.res_r, 32'd2);
        end
        bus.res_ready  = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_signed = 1'b0;
        bus.req_x      = 32'd9;
        bus.req_y      = 32'd4;
        exp_q.push_back({32'd2, 32'd1});
        #1;
        check("b2b req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b state", 32'(state_dbg), 32'(PREP));
        wait_result("b2b", 34);
        release_check("b2b");

        // Random operands against the reference model.
        for (int i = 0; i < 4; i++) begin
            rs = 1'($urandom_range(0, 1));
            rx = $urandom;
            ry = 32'($urandom_range(1, 50));
            if (rs && $urandom_range(0, 1) == 1) ry = ~ry + 1'b1;
            model(rs, rx, ry, rq, rr);
            run_op(rs, rx, ry, rq, rr, 34, "rand");
        end

        // Asynchronous reset in the middle of ITER.
        issue(1'b0, 32'd1000, 32'd3, "arst_op");
        repeat (5) @(negedge clk);
        check("arst pre_state", 32'(state_dbg), 32'(ITER));
        #2;
        resetn = 1'b0;
        #1;
        check("arst busy", 32'(busy), 32'd0);
        check("arst res_valid", 32'(bus.res_valid), 32'd0);
        check("arst state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 34, "post_arst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
